// File: rtl/dsack_responder_if.sv
// Bus bundle between a 68020/030-style CPU
// and the DSACK responder.
interface dsack_responder_if;
  logic       i_AS_n;
  logic       i_DS_n;
  logic       i_RW;
  logic       i_SEL;
  logic [1:0] i_SIZ;
  logic       i_A0;
  logic [1:0] o_DSACK_n;
  logic       o_BERR_n;
  logic       o_OE_n;
  logic       o_WE_UPPER_n;
  logic       o_WE_LOWER_n;
  logic       o_BUSY;

  modport master (
    output i_AS_n, i_DS_n, i_RW,
    output i_SEL, i_SIZ, i_A0,
    input  o_DSACK_n, o_BERR_n, o_OE_n,
    input  o_WE_UPPER_n, o_WE_LOWER_n,
    input  o_BUSY
  );

  modport slave (
    input  i_AS_n, i_DS_n, i_RW,
    input  i_SEL, i_SIZ, i_A0,
    output o_DSACK_n, o_BERR_n, o_OE_n,
    output o_WE_UPPER_n, o_WE_LOWER_n,
    output o_BUSY
  );
endinterface

// File: rtl/dsack_responder.sv
// Slave responder for the 68020/030 async bus:
// wait states, DSACK sizing, lane strobes, BERR watchdog.
module dsack_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int PORT_WIDTH  = 16,
  parameter int TIMEOUT     = 64
) (
  input logic               i_CLK,
  input logic               i_RESET_n,
  dsack_responder_if.slave  bus
);

  if (!(PORT_WIDTH == 8 || PORT_WIDTH == 16)) begin : g_bad_pw
    $error("dsack_responder: PORT_WIDTH must be 8 or 16");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wc
    $error("dsack_responder: WAIT_CYCLES out of 0..255");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_to
    $error("dsack_responder: TIMEOUT out of 1..255");
  end

  localparam bit PW8 = (PORT_WIDTH == 8);
  localparam logic [1:0] ACK_CODE =
    PW8 ? 2'b10 : 2'b01;
  localparam logic [7:0] WC_INIT = 8'(WAIT_CYCLES);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_UNMAP,
    S_BERR
  } state_t;

  state_t     state_q, state_d;
  logic       as_meta_q, as_s_q;
  logic       ds_meta_q, ds_s_q;
  logic       sel_q, rw_q, a0_q;
  logic [1:0] siz_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] wd_q, wd_d;
  logic       cap;
  logic [1:0] dsack_q, dsack_d;
  logic       berr_q, berr_d;
  logic       oe_q, oe_d;
  logic       weu_q, weu_d;
  logic       wel_q, wel_d;
  logic       busy_q, busy_d;
  logic       in_cyc_q, in_cyc_d, act;

  // Two-flop synchronisers for the async strobes.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      as_meta_q <= 1'b1;
      as_s_q    <= 1'b1;
      ds_meta_q <= 1'b1;
      ds_s_q    <= 1'b1;
    end else begin
      as_meta_q <= bus.i_AS_n;
      as_s_q    <= as_meta_q;
      ds_meta_q <= bus.i_DS_n;
      ds_s_q    <= ds_meta_q;
    end
  end

  // Next state, counters and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!as_s_q) begin
          cap = 1'b1;
          if (bus.i_SEL) begin
            state_d = S_WAIT;
            cnt_d   = WC_INIT;
          end else begin
            state_d = S_UNMAP;
            wd_d    = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (as_s_q)
          state_d = S_IDLE;
        else if (cnt_q == 8'd0)
          state_d = S_ACK;
        else
          cnt_d = cnt_q - 8'd1;
      end
      S_ACK: begin
        if (as_s_q) state_d = S_IDLE;
      end
      S_UNMAP: begin
        if (as_s_q)
          state_d = S_IDLE;
        else if (wd_q == WD_LAST)
          state_d = S_BERR;
        else
          wd_d = wd_q + 8'd1;
      end
      S_BERR: begin
        if (as_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes need a cycle already under way and
    // still under way after this edge.
    in_cyc_d = (state_d == S_WAIT) ||
               (state_d == S_ACK);
    act = in_cyc_q && in_cyc_d &&
          sel_q && !ds_s_q;
    oe_d  = !(act && rw_q);
    weu_d = !(act && !rw_q && (!a0_q || PW8));
    wel_d = !(act && !rw_q && !PW8 &&
              (a0_q || siz_q != 2'b01));
    dsack_d = (state_d == S_ACK) ? ACK_CODE : 2'b11;
    berr_d  = (state_d != S_BERR);
    busy_d  = (state_d != S_IDLE);
  end

  // FSM state, captured attributes and registered outputs.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      wd_q     <= 8'd0;
      sel_q    <= 1'b0;
      rw_q     <= 1'b1;
      a0_q     <= 1'b0;
      siz_q    <= 2'b00;
      in_cyc_q <= 1'b0;
      dsack_q  <= 2'b11;
      berr_q   <= 1'b1;
      oe_q     <= 1'b1;
      weu_q    <= 1'b1;
      wel_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      in_cyc_q <= in_cyc_d;
      if (cap) begin
        sel_q <= bus.i_SEL;
        rw_q  <= bus.i_RW;
        a0_q  <= bus.i_A0;
        siz_q <= bus.i_SIZ;
      end
      dsack_q <= dsack_d;
      berr_q  <= berr_d;
      oe_q    <= oe_d;
      weu_q   <= weu_d;
      wel_q   <= wel_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_DSACK_n    = dsack_q;
  assign bus.o_BERR_n     = berr_q;
  assign bus.o_OE_n       = oe_q;
  assign bus.o_WE_UPPER_n = weu_q;
  assign bus.o_WE_LOWER_n = wel_q;
  assign bus.o_BUSY       = busy_q;

endmodule

// File: tb/tb_dsack_responder.sv
// Scoreboard bench for dsack_responder: four
// instances, directed bus cycles, event monitor.
module tb_dsack_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic       as_n [4];
  logic       ds_n [4];
  logic       rw   [4];
  logic       sel  [4];
  logic       a0   [4];
  logic [1:0] siz  [4];
  logic [6:0] outv [4];
  logic [6:0] prev [4];

  typedef struct {
    int         id;
    int         cyc;
    logic [6:0] v;
  } ev_t;

  ev_t sbq[$];
  int  total = 0;
  int  bad   = 0;
  int  cur   = 0;
  int  k0    = 0;

  dsack_responder_if if0 ();
  dsack_responder_if if1 ();
  dsack_responder_if if2 ();
  dsack_responder_if if3 ();

  assign if0.i_AS_n = as_n[0];
  assign if0.i_DS_n = ds_n[0];
  assign if0.i_RW   = rw[0];
  assign if0.i_SEL  = sel[0];
  assign if0.i_SIZ  = siz[0];
  assign if0.i_A0   = a0[0];
  assign if1.i_AS_n = as_n[1];
  assign if1.i_DS_n = ds_n[1];
  assign if1.i_RW   = rw[1];
  assign if1.i_SEL  = sel[1];
  assign if1.i_SIZ  = siz[1];
  assign if1.i_A0   = a0[1];
  assign if2.i_AS_n = as_n[2];
  assign if2.i_DS_n = ds_n[2];
  assign if2.i_RW   = rw[2];
  assign if2.i_SEL  = sel[2];
  assign if2.i_SIZ  = siz[2];
  assign if2.i_A0   = a0[2];
  assign if3.i_AS_n = as_n[3];
  assign if3.i_DS_n = ds_n[3];
  assign if3.i_RW   = rw[3];
  assign if3.i_SEL  = sel[3];
  assign if3.i_SIZ  = siz[3];
  assign if3.i_A0   = a0[3];

  assign outv[0] = {if0.o_BUSY, if0.o_DSACK_n,
    if0.o_BERR_n, if0.o_OE_n,
    if0.o_WE_UPPER_n, if0.o_WE_LOWER_n};
  assign outv[1] = {if1.o_BUSY, if1.o_DSACK_n,
    if1.o_BERR_n, if1.o_OE_n,
    if1.o_WE_UPPER_n, if1.o_WE_LOWER_n};
  assign outv[2] = {if2.o_BUSY, if2.o_DSACK_n,
    if2.o_BERR_n, if2.o_OE_n,
    if2.o_WE_UPPER_n, if2.o_WE_LOWER_n};
  assign outv[3] = {if3.o_BUSY, if3.o_DSACK_n,
    if3.o_BERR_n, if3.o_OE_n,
    if3.o_WE_UPPER_n, if3.o_WE_LOWER_n};

  dsack_responder #(
    .WAIT_CYCLES(2), .PORT_WIDTH(16), .TIMEOUT(64)
  ) u0 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if0));

  dsack_responder #(
    .WAIT_CYCLES(2), .PORT_WIDTH(8), .TIMEOUT(64)
  ) u1 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if1));

  dsack_responder #(
    .WAIT_CYCLES(0), .PORT_WIDTH(16), .TIMEOUT(1)
  ) u2 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if2));

  dsack_responder #(
    .WAIT_CYCLES(10), .PORT_WIDTH(16), .TIMEOUT(64)
  ) u3 (.i_CLK(clk), .i_RESET_n(rst_n), .bus(if3));

  // vector bits: busy, dsack[1:0], berr, oe, weu, wel
  localparam logic [6:0] V_IDLE = 7'b0111111;
  localparam logic [6:0] V_BUSY = 7'b1111111;

  task automatic start(input int id, input logic r,
                       input logic [1:0] s,
                       input logic a, input logic sl);
    @(negedge clk);
    cur      = id;
    rw[id]   = r;
    siz[id]  = s;
    a0[id]   = a;
    sel[id]  = sl;
    as_n[id] = 1'b0;
    ds_n[id] = 1'b0;
    k0       = edge_n + 1;
  endtask

  task automatic ex(input int off,
                    input logic [6:0] v);
    ev_t e;
    e.id  = cur;
    e.cyc = k0 + off;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic wait_to(input int off);
    while (edge_n < k0 + off) @(negedge clk);
  endtask

  task automatic neg(input int off);
    wait_to(off - 1);
    as_n[cur] = 1'b1;
    ds_n[cur] = 1'b1;
  endtask

  // One whole cycle: busy at 2, up to two
  // output changes, AS released at edge no.
  task automatic run(input int id, input logic r,
                     input logic [1:0] s,
                     input logic a, input logic sl,
                     input int o1, input logic [6:0] v1,
                     input int o2, input logic [6:0] v2,
                     input int no);
    start(id, r, s, a, sl);
    ex(2, V_BUSY);
    ex(o1, v1);
    if (o2 >= 0) ex(o2, v2);
    ex(no + 2, V_IDLE);
    neg(no);
    wait_to(no + 2);
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (rst_n === 1'b1 && outv[i] !== prev[i]) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected id=%0d cyc=%0d got=%b",
                     i, edge_n, outv[i]);
          end else begin
            ev_t e;
            e = sbq.pop_front();
            total++;
            if (e.id != i || e.cyc != edge_n ||
                e.v !== outv[i]) begin
              bad++;
              $display("FAIL event id=%0d cyc=%0d got=%b exp id=%0d cyc=%0d v=%b",
                       i, edge_n, outv[i],
                       e.id, e.cyc, e.v);
            end
          end
        end
        prev[i] = outv[i];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      as_n[i] = 1'b1;
      ds_n[i] = 1'b1;
      rw[i]   = 1'b1;
      sel[i]  = 1'b0;
      a0[i]   = 1'b0;
      siz[i]  = 2'b00;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    fork
      mon_loop();
    join_none
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (outv[i] !== V_IDLE) begin
        bad++;
        $display("FAIL reset id=%0d got=%b exp=%b",
                 i, outv[i], V_IDLE);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // word read, 16-bit port, 2 waits
    run(0, 1'b1, 2'b10, 1'b0, 1'b1,
        3, 7'b1111011, 5, 7'b1011011, 8);
    // byte writes and long write, 16-bit port
    run(0, 1'b0, 2'b01, 1'b1, 1'b1,
        3, 7'b1111110, 5, 7'b1011110, 8);
    run(0, 1'b0, 2'b01, 1'b0, 1'b1,
        3, 7'b1111101, 5, 7'b1011101, 8);
    run(0, 1'b0, 2'b00, 1'b0, 1'b1,
        3, 7'b1111100, 5, 7'b1011100, 8);
    // 8-bit port: upper lane only, DSACK=10
    run(1, 1'b0, 2'b01, 1'b1, 1'b1,
        3, 7'b1111101, 5, 7'b1101101, 8);
    run(1, 1'b0, 2'b00, 1'b0, 1'b1,
        3, 7'b1111101, 5, 7'b1101101, 8);
    run(1, 1'b1, 2'b10, 1'b0, 1'b1,
        3, 7'b1111011, 5, 7'b1101011, 8);
    // unmapped: BERR after edge 66
    run(0, 1'b1, 2'b10, 1'b0, 1'b0,
        66, 7'b1110111, -1, 7'b0, 70);
    // abort in WAIT, then back-to-back access
    run(3, 1'b0, 2'b01, 1'b1, 1'b1,
        3, 7'b1111110, -1, 7'b0, 3);
    run(3, 1'b1, 2'b10, 1'b0, 1'b1,
        3, 7'b1111011, 13, 7'b1011011, 16);

    // zero waits; SEL/A0 move after capture
    start(2, 1'b0, 2'b10, 1'b0, 1'b1);
    ex(2, V_BUSY);
    ex(3, 7'b1011100);
    ex(9, V_IDLE);
    wait_to(3);
    sel[2] = 1'b0;
    a0[2]  = 1'b1;
    neg(7);
    wait_to(9);
    // TIMEOUT=1: BERR one clock into UNMAP
    run(2, 1'b1, 2'b10, 1'b0, 1'b0,
        3, 7'b1110111, -1, 7'b0, 5);

    // async reset while in ACK
    start(0, 1'b1, 2'b10, 1'b0, 1'b1);
    ex(2, V_BUSY);
    ex(3, 7'b1111011);
    ex(5, 7'b1011011);
    ex(7, V_IDLE);
    wait_to(6);
    #1;
    rst_n   = 1'b0;
    as_n[0] = 1'b1;
    ds_n[0] = 1'b1;
    #1;
    total++;
    if (outv[0] !== V_IDLE) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b",
               outv[0], V_IDLE);
    end
    #1 rst_n = 1'b1;
    wait_to(8);
    run(0, 1'b1, 2'b10, 1'b0, 1'b1,
        3, 7'b1111011, 5, 7'b1011011, 8);

    repeat (4) @(negedge clk);
    while (sbq.size() != 0) begin
      ev_t e;
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missing id=%0d cyc=%0d exp=%b",
               e.id, e.cyc, e.v);
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/dsack_responder.md
Name: dsack_responder

Overview:
- Slave-side responder for the 68020/030-style asynchronous bus, on a narrow peripheral or memory region behind the CPU glue.
- Watches AS_n/DS_n and a decoded chip select, then inserts a programmable number of wait states and returns DSACK_n for its configured port size.
- Drives lane write strobes and output enable for the attached device.
- For unmapped accesses it runs a watchdog and returns BERR_n, so the CPU never hangs.

Parameters:
- WAIT_CYCLES, 2, wait-state clocks between the decoded access and DSACK assertion (0..255).
- PORT_WIDTH, 16, port size reported on DSACK_n. Only 8 and 16 are legal; any other value is an elaboration error.
- TIMEOUT, 64, clocks an unselected access may stay pending before BERR_n asserts (1..255).

Ports:
- i_CLK  in  1  system clock
- i_RESET_n  in  1  asynchronous active-low reset
- i_AS_n  in  1  CPU address strobe, asynchronous to i_CLK
- i_DS_n  in  1  CPU data strobe, asynchronous to i_CLK
- i_RW  in  1  1 = read, 0 = write
- i_SEL  in  1  decoded chip select for this region, active high
- i_SIZ  in  2  CPU transfer size: 01 byte, 10 word, 11 three-byte, 00 long
- i_A0  in  1  address bit 0
- o_DSACK_n  out  2  [1] = DSACK1_n, [0] = DSACK0_n
- o_BERR_n  out  1  bus error, active low
- o_OE_n  out  1  device output enable, active low
- o_WE_UPPER_n  out  1  write strobe for lane D31:24, active low
- o_WE_LOWER_n  out  1  write strobe for lane D23:16, active low
- o_BUSY  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (async, i_RESET_n low):
  - State = IDLE; synchronisers = 1; counters = 0.
  - Outputs: o_DSACK_n = 2'b11, o_BERR_n = 1, o_OE_n = 1, o_WE_UPPER_n = 1, o_WE_LOWER_n = 1, o_BUSY = 0.
  - Reset asserted mid-cycle aborts immediately, with no partial acknowledge.
- Synchronisation:
  - i_AS_n and i_DS_n each pass through a 2-flop synchroniser, giving as_s and ds_s.
  - i_SEL, i_RW, i_SIZ and i_A0 are captured into registers on the edge where the state leaves IDLE. They are held for the whole cycle.
- All outputs are registered. None is a combinational path from an input.
- States: IDLE, WAIT, ACK, UNMAP, BERR.
- IDLE:
  - If as_s = 0 and SEL = 1: go to WAIT and load the wait counter with WAIT_CYCLES.
  - If as_s = 0 and SEL = 0: go to UNMAP and load the watchdog with 0.
- WAIT:
  - Counter = 0: go to ACK.
  - Otherwise: decrement the counter.
  - WAIT_CYCLES = 0 spends exactly one clock in WAIT.
- ACK:
  - o_DSACK_n = 2'b01 when PORT_WIDTH = 16, or 2'b10 when PORT_WIDTH = 8.
  - Hold until as_s = 1, then return to IDLE.
- UNMAP:
  - Increment the watchdog each clock.
  - When the watchdog reaches TIMEOUT-1, go to BERR.
- BERR:
  - o_BERR_n = 0, o_DSACK_n = 2'b11.
  - Hold until as_s = 1, then return to IDLE.
- Abort: as_s = 1 while in WAIT or UNMAP returns to IDLE next edge. No DSACK_n and no BERR_n are asserted.
- Latency: let edge k0 be the first edge that samples i_AS_n low.
  - State enters WAIT at edge k0+2.
  - o_DSACK_n asserts after edge k0+3+WAIT_CYCLES.
  - BERR_n asserts after edge k0+2+TIMEOUT.
- Release: let edge j0 be the first edge that samples i_AS_n high while in ACK or BERR.
  - Outputs negate and state is IDLE after edge j0+2.
  - A new access is accepted from IDLE only after that point.
- Lane strobes:
  - Valid only in WAIT/ACK, when ds_s = 0 and RW = 0.
  - o_WE_UPPER_n = 0 when A0 = 0, or when PORT_WIDTH = 8.
  - o_WE_LOWER_n = 0 when PORT_WIDTH = 16 and (A0 = 1 or SIZ != 01).
  - o_OE_n = 0 in WAIT/ACK when ds_s = 0 and RW = 1.
- DS_n gating:
  - ds_s negating during WAIT/ACK negates the strobes on the next edge. The state is not changed.
  - DS_n never asserting still completes the cycle; DSACK_n is gated by AS_n only.
- Watchdog:
  - Counts only in UNMAP. Selected slow accesses never raise BERR_n.
  - TIMEOUT = 1 asserts BERR_n one clock after UNMAP is entered.

Test Plan:
- Word read, WAIT_CYCLES = 2, PORT_WIDTH = 16, SEL = 1, RW = 1, A0 = 0, SIZ = 10, AS/DS low at edge 0 -> o_OE_n low from edge 3; o_DSACK_n = 01 after edge 5; AS high at edge 8 -> o_DSACK_n = 11, o_OE_n = 1, o_BUSY = 0 after edge 10.
- Byte write, SIZ = 01: A0 = 1 -> only o_WE_LOWER_n low; A0 = 0 -> only o_WE_UPPER_n low. Long write at A0 = 0 -> both strobes low. PORT_WIDTH = 8 -> only o_WE_UPPER_n low and o_DSACK_n = 10 in every case.
- Unmapped access, SEL = 0, TIMEOUT = 64, AS low at edge 0 -> o_BERR_n low after edge 66, DSACK_n stays 11; AS high at edge 70 -> o_BERR_n high after edge 72.
- Abort: AS negated at edge 3 with WAIT_CYCLES = 10 -> DSACK_n and BERR_n never assert; state is IDLE after edge 5; a back-to-back access at edge 7 completes normally.
- WAIT_CYCLES = 0 -> DSACK_n asserts after edge 3. i_SEL and i_A0 changing after capture do not alter the strobes or DSACK_n.
- i_RESET_n pulsed low while in ACK -> all outputs immediately at reset values with no clock edge; the next access behaves as the first case.
